// File: rtl/frame_ring_arbiter.sv
// N-channel, M-slot frame ring manager: slot ownership, word offsets and SDRAM addresses.
// Define FRAME_RING_STATS_EN to add per-channel saturating drop/repeat counters.
module frame_ring_arbiter #(
    parameter int unsigned       NUM_CH      = 3,
    parameter int unsigned       NUM_SLOTS   = 3,
    parameter int unsigned       ADDR_W      = 26,
    parameter logic [ADDR_W-1:0] FRAME_WORDS = 26'h0020000,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 26'h1000000,
    parameter logic [ADDR_W-1:0] SLOT_STRIDE = 26'h0020000,
    parameter logic [ADDR_W-1:0] CH_STRIDE   = 26'h0100000,
    localparam int unsigned      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    input  logic [CH_W-1:0]   prod_ch,
    output logic              prod_ready,
    output logic [ADDR_W-1:0] prod_addr,
    output logic              prod_last,
    input  logic              cons_valid,
    input  logic [CH_W-1:0]   cons_ch,
    output logic              cons_ready,
    output logic [ADDR_W-1:0] cons_addr,
    output logic              cons_last,
    output logic [NUM_CH-1:0] cons_fresh,
    input  logic [NUM_CH-1:0] flush
`ifdef FRAME_RING_STATS_EN
    ,
    output logic [NUM_CH-1:0][15:0] drop_cnt,
    output logic [NUM_CH-1:0][15:0] repeat_cnt
`endif
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    // Ages are compared modulo 2^AGE_W; live READY ages never span half of that range.
    localparam int unsigned AGE_W  = SLOT_W + 2;
    localparam logic [ADDR_W-1:0] LAST_OFS = FRAME_WORDS - ADDR_W'(1);

    localparam logic [1:0] S_FREE    = 2'd0;
    localparam logic [1:0] S_WRITING = 2'd1;
    localparam logic [1:0] S_READY   = 2'd2;
    localparam logic [1:0] S_READING = 2'd3;

    if (NUM_SLOTS < 3) begin : g_bad_slots
        $error("frame_ring_arbiter: NUM_SLOTS must be >= 3");
    end
    if (SLOT_STRIDE < FRAME_WORDS) begin : g_bad_slot_stride
        $error("frame_ring_arbiter: SLOT_STRIDE must be >= FRAME_WORDS");
    end
    if (64'(CH_STRIDE) < 64'(NUM_SLOTS) * 64'(SLOT_STRIDE)) begin : g_bad_ch_stride
        $error("frame_ring_arbiter: CH_STRIDE must be >= NUM_SLOTS*SLOT_STRIDE");
    end

    logic [1:0]        st_q   [NUM_CH][NUM_SLOTS];
    logic [1:0]        st_d   [NUM_CH][NUM_SLOTS];
    logic [AGE_W-1:0]  age_q  [NUM_CH][NUM_SLOTS];
    logic [AGE_W-1:0]  age_d  [NUM_CH][NUM_SLOTS];
    logic [AGE_W-1:0]  cnt_q  [NUM_CH];
    logic [AGE_W-1:0]  cnt_d  [NUM_CH];
    logic [SLOT_W-1:0] wr_q   [NUM_CH];
    logic [SLOT_W-1:0] wr_d   [NUM_CH];
    logic [SLOT_W-1:0] rd_q   [NUM_CH];
    logic [SLOT_W-1:0] rd_d   [NUM_CH];
    logic [ADDR_W-1:0] pofs_q [NUM_CH];
    logic [ADDR_W-1:0] pofs_d [NUM_CH];
    logic [ADDR_W-1:0] cofs_q [NUM_CH];
    logic [ADDR_W-1:0] cofs_d [NUM_CH];
    logic [NUM_CH-1:0] fresh_q, fresh_d;
`ifdef FRAME_RING_STATS_EN
    logic [15:0]       drop_q [NUM_CH];
    logic [15:0]       drop_d [NUM_CH];
    logic [15:0]       rep_q  [NUM_CH];
    logic [15:0]       rep_d  [NUM_CH];

    function automatic logic [15:0] sat_add(input logic [15:0] a, input int unsigned n);
        int unsigned t;
        t = 32'(a) + n;
        return (t > 32'h0000_FFFF) ? 16'hFFFF : 16'(t);
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stats_out
        assign drop_cnt[g]   = drop_q[g];
        assign repeat_cnt[g] = rep_q[g];
    end
`endif

    function automatic logic [1:0] rst_state(input int unsigned s);
        return (s == 0) ? S_READING : (s == 1) ? S_WRITING : S_FREE;
    endfunction

    function automatic logic newer(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = a - b;
        return (d != '0) && !d[AGE_W-1];
    endfunction

    assign cons_fresh = fresh_q;

    // Beat acceptance and addresses are combinational from registered slot/offset state.
    always_comb begin : beat_outputs
        prod_ready = prod_valid & rst;
        cons_ready = cons_valid & rst;
        prod_addr  = '0;
        prod_last  = 1'b0;
        cons_addr  = '0;
        cons_last  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (prod_ready && prod_ch == CH_W'(c)) begin
                prod_addr = BASE_ADDR + ADDR_W'(c) * CH_STRIDE
                          + ADDR_W'(wr_q[c]) * SLOT_STRIDE + pofs_q[c];
                prod_last = (pofs_q[c] == LAST_OFS);
            end
            if (cons_ready && cons_ch == CH_W'(c)) begin
                cons_addr = BASE_ADDR + ADDR_W'(c) * CH_STRIDE
                          + ADDR_W'(rd_q[c]) * SLOT_STRIDE + cofs_q[c];
                cons_last = (cofs_q[c] == LAST_OFS);
            end
        end
    end

    always_comb begin : next_state
        logic pb, cb, pl, cl, found, got_free;
        logic [SLOT_W-1:0] newest, oldest, free_s, nxt_w;
`ifdef FRAME_RING_STATS_EN
        int unsigned drops;
`endif
        st_d    = st_q;
        age_d   = age_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        pofs_d  = pofs_q;
        cofs_d  = cofs_q;
        fresh_d = fresh_q;
`ifdef FRAME_RING_STATS_EN
        drop_d  = drop_q;
        rep_d   = rep_q;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            pb       = prod_ready && (prod_ch == CH_W'(c));
            cb       = cons_ready && (cons_ch == CH_W'(c));
            pl       = pb && prod_last;
            cl       = cb && cons_last;
            found    = 1'b0;
            got_free = 1'b0;
            newest   = '0;
            oldest   = '0;
            free_s   = '0;
            nxt_w    = '0;
`ifdef FRAME_RING_STATS_EN
            drops    = 0;
`endif
            // Survey start-of-cycle slot states; the producer's commit this cycle is not visible.
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (st_q[c][s] == S_READY) begin
                    if (!found || newer(age_q[c][s], age_q[c][newest])) newest = SLOT_W'(s);
                    if (!found || newer(age_q[c][oldest], age_q[c][s])) oldest = SLOT_W'(s);
                    found = 1'b1;
                end
                if (!got_free && st_q[c][s] == S_FREE) begin
                    free_s   = SLOT_W'(s);
                    got_free = 1'b1;
                end
            end

            if (cb) cofs_d[c] = cl ? '0 : cofs_q[c] + ADDR_W'(1);
            if (cl && found) begin
                st_d[c][rd_q[c]] = S_FREE;
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (st_q[c][s] == S_READY && SLOT_W'(s) != newest) begin
                        st_d[c][s] = S_FREE;
`ifdef FRAME_RING_STATS_EN
                        drops++;
`endif
                    end
                end
                st_d[c][newest] = S_READING;
                rd_d[c]         = newest;
                fresh_d[c]      = 1'b1;
            end
`ifdef FRAME_RING_STATS_EN
            if (cl && !found) rep_d[c] = sat_add(rep_q[c], 1);
`endif

            if (pb) pofs_d[c] = pl ? '0 : pofs_q[c] + ADDR_W'(1);
            if (pl) begin
                st_d[c][wr_q[c]]  = S_READY;
                age_d[c][wr_q[c]] = cnt_q[c];
                cnt_d[c]          = cnt_q[c] + AGE_W'(1);
                if (got_free) begin
                    nxt_w = free_s;
                end else if (cl && found) begin
                    nxt_w = rd_q[c];
                end else begin
                    nxt_w = oldest;
`ifdef FRAME_RING_STATS_EN
                    drops++;
`endif
                end
                st_d[c][nxt_w] = S_WRITING;
                wr_d[c]        = nxt_w;
            end
`ifdef FRAME_RING_STATS_EN
            drop_d[c] = sat_add(drop_q[c], drops);
`endif

            // Flush wins over any beat on the channel this cycle.
            if (flush[c]) begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    st_d[c][s]  = rst_state(s);
                    age_d[c][s] = '0;
                end
                cnt_d[c]   = '0;
                wr_d[c]    = SLOT_W'(1);
                rd_d[c]    = '0;
                pofs_d[c]  = '0;
                cofs_d[c]  = '0;
                fresh_d[c] = 1'b0;
`ifdef FRAME_RING_STATS_EN
                drop_d[c]  = '0;
                rep_d[c]   = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin : state_regs
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    st_q[c][s]  <= rst_state(s);
                    age_q[c][s] <= '0;
                end
                cnt_q[c]  <= '0;
                wr_q[c]   <= SLOT_W'(1);
                rd_q[c]   <= '0;
                pofs_q[c] <= '0;
                cofs_q[c] <= '0;
`ifdef FRAME_RING_STATS_EN
                drop_q[c] <= '0;
                rep_q[c]  <= '0;
`endif
            end
            fresh_q <= '0;
        end else begin
            st_q    <= st_d;
            age_q   <= age_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            pofs_q  <= pofs_d;
            cofs_q  <= cofs_d;
            fresh_q <= fresh_d;
`ifdef FRAME_RING_STATS_EN
            drop_q  <= drop_d;
            rep_q   <= rep_d;
`endif
        end
    end

endmodule
